// File: rtl/snd_dsdac_out.sv
// Multi-channel first-order delta-sigma audio output with a frame FIFO and a sample-rate divider.
// Optional build macro SND_DSDAC_VOLUME_EN adds the vol port (arithmetic attenuation applied at pop).
module snd_dsdac_out #(
  parameter int CH    = 2,
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int DIV   = 1134
) (
  input  logic                         m_clock,
  input  logic                         p_reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH*W-1:0]              in_data,
  input  logic                         clr_underrun,
  output logic                         underrun,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
`ifdef SND_DSDAC_VOLUME_EN
  input  logic [3:0]                   vol,
`endif
  output logic [CH-1:0]                dout
);

  localparam int CW = $clog2(DIV);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef logic [W-1:0] sample_t;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            underrun_q, underrun_d;
  logic [CH-1:0]   dout_q, dout_d;
  logic [CH*W-1:0] mem_q [DEPTH];
  sample_t         cur_q [CH];
  sample_t         cur_d [CH];
  sample_t         acc_q [CH];
  sample_t         acc_d [CH];

  logic strobe, push, pop;

  assign strobe     = (cnt_q == CW'(DIV - 1));
  assign in_ready   = (level_q != LW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = strobe && (level_q != '0);
  assign underrun   = underrun_q;
  assign fifo_level = level_q;
  assign dout       = dout_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d      = strobe ? '0 : cnt_q + 1'b1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    underrun_d = underrun_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // An empty strobe wins over a same-cycle clear so no underrun is ever lost.
    if (strobe && (level_q == '0)) underrun_d = 1'b1;
    else if (clr_underrun)         underrun_d = 1'b0;
  end

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      logic [W:0] sum;
      sample_t    head;
      cur_d[k] = cur_q[k];
      head     = mem_q[rd_ptr_q][k*W +: W];
`ifdef SND_DSDAC_VOLUME_EN
      if (pop) cur_d[k] = sample_t'($signed(head) >>> vol);
`else
      if (pop) cur_d[k] = head;
`endif
      // Offset binary: flipping the sign bit maps -2^(W-1) to 0 and 2^(W-1)-1 to full scale.
      sum       = {1'b0, acc_q[k]} + {1'b0, cur_q[k] ^ sample_t'(1 << (W - 1))};
      acc_d[k]  = sum[W-1:0];
      dout_d[k] = sum[W];
    end
  end

  // NOTE: the frame storage has no reset; reset empties the FIFO through the pointers and level instead.
  always_ff @(posedge m_clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
      dout_q     <= '0;
      for (int k = 0; k < CH; k++) begin
        cur_q[k] <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
      dout_q     <= dout_d;
      for (int k = 0; k < CH; k++) begin
        cur_q[k] <= cur_d[k];
        acc_q[k] <= acc_d[k];
      end
    end
  end

endmodule

// File: tb/tb_snd_dsdac_out.sv
// Scoreboard bench for snd_dsdac_out (CH=2, W=8, DEPTH=4, DIV=8): stimulus queues expectations,
// a negedge monitor pops and compares them, and counts dout ones over sliding windows.
module tb_snd_dsdac_out;

  logic       m_clock = 1'b0;
  logic       p_reset;
  logic       in_valid;
  logic       in_ready;
  logic [15:0] in_data;
  logic       clr_underrun;
  logic       underrun;
  logic [2:0] fifo_level;
  logic [1:0] dout;
`ifdef SND_DSDAC_VOLUME_EN
  logic [3:0] vol;
`endif

  snd_dsdac_out #(.CH(2), .W(8), .DEPTH(4), .DIV(8)) dut (
    .m_clock      (m_clock),
    .p_reset      (p_reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .clr_underrun (clr_underrun),
    .underrun     (underrun),
    .fifo_level   (fifo_level),
`ifdef SND_DSDAC_VOLUME_EN
    .vol          (vol),
`endif
    .dout         (dout)
  );

  always #5 m_clock = ~m_clock;

  typedef enum {K_READY, K_LEVEL, K_UNDER, K_DOUT, K_ONES} kind_e;
  typedef struct {
    string name;
    kind_e kind;
    int    ch;
    int    win;
    int    exp;
  } item_t;

  item_t        sb[$];
  logic [255:0] hist [2];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ones(input int ch, input int win);
    int c = 0;
    for (int i = 0; i < win; i++) if (hist[ch][i]) c++;
    return c;
  endfunction

  function automatic int observe(input item_t it);
    case (it.kind)
      K_READY: return int'(in_ready);
      K_LEVEL: return int'(fifo_level);
      K_UNDER: return int'(underrun);
      K_DOUT:  return int'(dout);
      default: return ones(it.ch, it.win);
    endcase
  endfunction

  // Monitor: record this cycle's dout, then settle every expectation queued for this cycle.
  initial begin
    hist[0] = '0;
    hist[1] = '0;
    forever begin
      @(negedge m_clock);
      hist[0] = {hist[0][254:0], dout[0]};
      hist[1] = {hist[1][254:0], dout[1]};
      while (sb.size() != 0) begin
        item_t it;
        it = sb.pop_front();
        check(it.name, observe(it), it.exp);
      end
    end
  end

  task automatic want(input string name, input kind_e k, input int exp);
    item_t it;
    it.name = name; it.kind = k; it.ch = 0; it.win = 0; it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic want_ones(input string name, input int ch, input int win, input int exp);
    item_t it;
    it.name = name; it.kind = K_ONES; it.ch = ch; it.win = win; it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic tick();
    @(posedge m_clock);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic frame(input logic [7:0] c0, input logic [7:0] c1);
    in_data = {c1, c0};
  endtask

  // Frames whose offset codes are multiples of 32, so an 8-cycle window holds exactly u/32 ones.
  logic [7:0] f_c0 [5] = '{8'hA0, 8'hE0, 8'h20, 8'h60, 8'hC0};
  logic [7:0] f_c1 [5] = '{8'h40, 8'h80, 8'h00, 8'hA0, 8'h60};
  int         e_c0 [5] = '{1, 3, 5, 7, 2};
  int         e_c1 [5] = '{6, 0, 4, 1, 7};

  initial begin
    p_reset = 1'b1; in_valid = 1'b0; in_data = '0; clr_underrun = 1'b0;
`ifdef SND_DSDAC_VOLUME_EN
    vol = 4'd0;
`endif
    repeat (3) tick();
    p_reset = 1'b0;
    cyc = 0;

    // Idle after reset: mid-scale on both channels, underrun only after the first strobe.
    want("rst_ready", K_READY, 1); want("rst_level", K_LEVEL, 0);
    want("rst_under", K_UNDER, 0); want("rst_dout", K_DOUT, 0);
    go_to(1); want("idle_dout_c1", K_DOUT, 0);
    go_to(2); want("idle_dout_c2", K_DOUT, 3);
    go_to(7); want("under_before_strobe", K_UNDER, 0);
    go_to(8); want("under_after_strobe", K_UNDER, 1);
    go_to(256);
    want_ones("idle_duty_ch0", 0, 256, 128); want_ones("idle_duty_ch1", 1, 256, 128);

    // Clear works off-strobe; an empty strobe beats a same-cycle clear.
    go_to(257); clr_underrun = 1'b1;
    go_to(258); clr_underrun = 1'b0; want("clr_under", K_UNDER, 0);
    go_to(263); clr_underrun = 1'b1;
    go_to(264); clr_underrun = 1'b0; want("set_beats_clr", K_UNDER, 1);

    // Single frame {ch1=0xC0, ch0=0x40}.
    in_valid = 1'b1; frame(8'h40, 8'hC0);
    go_to(265); in_valid = 1'b0; want("one_level", K_LEVEL, 1); clr_underrun = 1'b1;
    go_to(266); clr_underrun = 1'b0;
    go_to(272); want("one_popped", K_LEVEL, 0); want("one_no_under", K_UNDER, 0);
    go_to(528);
    want_ones("one_duty_ch0", 0, 256, 192); want_ones("one_duty_ch1", 1, 256, 64);

    // Five frames with in_valid held: four fill the FIFO, the fifth enters after the next pop.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      go_to(528 + i); frame(f_c0[i], f_c1[i]);
    end
    go_to(532); want("full_level", K_LEVEL, 4); want("full_ready", K_READY, 0);
    go_to(535); want("full_strobe_ready", K_READY, 0); want("full_strobe_level", K_LEVEL, 4);
    go_to(536); want("after_pop_level", K_LEVEL, 3); want("after_pop_ready", K_READY, 1);
    go_to(537); in_valid = 1'b0; want("refill_level", K_LEVEL, 4); want("refill_ready", K_READY, 0);
    for (int i = 0; i < 5; i++) begin
      go_to(544 + 8 * i);
      want_ones($sformatf("order_f%0d_ch0", i), 0, 8, e_c0[i]);
      want_ones($sformatf("order_f%0d_ch1", i), 1, 8, e_c1[i]);
    end
    go_to(576); want("drained_under", K_UNDER, 1); want("drained_level", K_LEVEL, 0);

    // Push into an empty FIFO exactly on the strobe cycle.
    go_to(577); clr_underrun = 1'b1;
    go_to(578); clr_underrun = 1'b0; want("clr_under2", K_UNDER, 0);
    go_to(583); in_valid = 1'b1; frame(8'h00, 8'hE0);
    go_to(584); in_valid = 1'b0; want("edge_push_under", K_UNDER, 1); want("edge_push_level", K_LEVEL, 1);
    go_to(592); want("edge_push_popped", K_LEVEL, 0);
    go_to(600);
    want_ones("edge_push_ch0", 0, 8, 4); want_ones("edge_push_ch1", 1, 8, 3);

    // Reset mid-period with three frames buffered.
    go_to(601); in_valid = 1'b1; frame(8'h80, 8'h80);
    go_to(604); in_valid = 1'b0; want("pre_reset_level", K_LEVEL, 3);
    go_to(605); p_reset = 1'b1;
    go_to(606); p_reset = 1'b0; cyc = 0;
    want("mid_rst_level", K_LEVEL, 0); want("mid_rst_ready", K_READY, 1);
    want("mid_rst_dout", K_DOUT, 0); want("mid_rst_under", K_UNDER, 0);
    go_to(1); in_valid = 1'b1; frame(8'h60, 8'hA0);
    go_to(2); in_valid = 1'b0;
    go_to(3); want("post_rst_level", K_LEVEL, 1);
    go_to(7); want("post_rst_hold", K_LEVEL, 1); want("post_rst_under7", K_UNDER, 0);
    go_to(8); want("post_rst_pop", K_LEVEL, 0); want("post_rst_under8", K_UNDER, 0);
    go_to(16);
    want_ones("post_rst_ch0", 0, 8, 7); want_ones("post_rst_ch1", 1, 8, 1);
    want("post_rst_under16", K_UNDER, 1);

`ifdef SND_DSDAC_VOLUME_EN
    // vol=2 at the pop: 0x40 -> 0x10 (code 144), 0x80 -> 0xE0 (code 96).
    go_to(17); in_valid = 1'b1; frame(8'h40, 8'h80); vol = 4'd2;
    go_to(18); in_valid = 1'b0;
    go_to(24); vol = 4'd0;
    go_to(280);
    want_ones("vol_ch0", 0, 256, 144); want_ones("vol_ch1", 1, 256, 96);
`endif

    tick();
    @(negedge m_clock);
    #1;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
